irrigation_pump_controller: RTL and testbench
=============================================

Name: irrigation_pump_controller

Overview:
- Sequential actuator stage directly downstream of the fuzzy irrigation block.
- Consumes that block's irrigation_time and rain_present outputs and turns one requested irrigation into a timed pump-on interval.
- Applies rain lockout, manual stop and a post-run cooldown.
- Drives the pump/valve enable and status flags for the top level.

Parameters:
- TICK_CYCLES, 50_000_000, clock cycles per irrigation_time unit (1 unit = 1 s at 50 MHz).
- MAX_UNITS, 60, clamp on the requested duration, in units.
- COOLDOWN_UNITS, 30, lockout after any run ends (done or abort), in units; 0 = no cooldown.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle irrigation request.
- irrigation_time  in  8  requested duration in units, from fuzzy stage.
- rain_present  in  1  rain flag from fuzzy stage.
- manual_stop  in  1  operator abort, level.
- pump_on  out  1  pump/valve enable.
- busy  out  1  high in RUN or COOLDOWN.
- remaining  out  8  units left in the current RUN or COOLDOWN.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on rain or manual abort.
- rejected  out  1  one-cycle pulse when start is refused.
- state  out  2  00 IDLE, 01 RUN, 10 COOLDOWN.

Behaviour:
- Clock and reset
  - One clock domain; reset is asynchronous and active-low.
  - Reset asserted, at any time including mid-run: state=IDLE; pump_on, busy, done, aborted, rejected = 0; remaining=0; prescaler=0.
  - Pump drops immediately on reset assertion, not at the next edge.
- All outputs are registered.
- IDLE
  - start=1 with rain_present=0, manual_stop=0 and irrigation_time!=0: latch remaining = min(irrigation_time, MAX_UNITS), clear prescaler, go RUN. pump_on=1 and busy=1 from the next cycle.
  - start=1 with rain_present=1, manual_stop=1 or irrigation_time=0: stay IDLE and pulse rejected for one cycle.
  - irrigation_time is sampled only on the accepted start cycle; later changes are ignored.
- RUN
  - Prescaler counts 0..TICK_CYCLES-1 and wraps.
  - On the wrap cycle, remaining decrements.
  - When remaining is 1 at wrap: pulse done, pump_on=0 and go COOLDOWN on the next cycle.
  - Pump-on duration is exactly remaining_latched*TICK_CYCLES cycles.
  - rain_present=1 or manual_stop=1 in any RUN cycle: pulse aborted, pump_on=0 next cycle, go COOLDOWN.
  - Abort and final tick in the same cycle: abort wins and done is not pulsed.
  - start during RUN: ignored, no rejected pulse.
- COOLDOWN
  - Load remaining=COOLDOWN_UNITS and clear prescaler on entry; decrement on each prescaler wrap.
  - Go IDLE when the tick takes remaining to 0.
  - COOLDOWN_UNITS=0: go directly RUN to IDLE with busy deasserted the same cycle pump_on drops.
  - start during COOLDOWN: pulse rejected and stay in COOLDOWN.
  - rain and manual_stop have no effect in COOLDOWN.
- Widths
  - Prescaler width is clog2(TICK_CYCLES); remaining is 8 bit and never underflows.
  - MAX_UNITS > 255 is treated as 255.
- Pulse rule: at most one of done, aborted, rejected is high in any cycle.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE/RUN/COOLDOWN;
  - default TICK_CYCLES, MAX_UNITS, COOLDOWN_UNITS;
  - a clamp function for duration.
- One sub-module, irrigation_tick_prescaler: parameter TICK_CYCLES; inputs clk, reset, clear, enable; output tick, a one-cycle pulse on wrap.
- The FSM and counters stay in irrigation_pump_controller.

Test Plan:
- Normal run (TICK_CYCLES=4, COOLDOWN_UNITS=2): start with irrigation_time=10, rain 0 -> pump_on high for exactly 40 cycles starting the cycle after start; done pulses once; busy stays high 8 more cycles; state returns 00.
- Clamp and reject (MAX_UNITS=60): start with irrigation_time=200 -> pump_on for 240 cycles. Start with irrigation_time=0 -> rejected 1 cycle, pump_on stays 0. Start while rain_present=1 -> rejected, state stays 00.
- Rain abort: start with time 45; raise rain_present at cycle 20 -> aborted pulse; pump_on 0 next cycle; state=10 with remaining=2; done never asserts.
- Simultaneous: assert manual_stop on the final prescaler wrap of a 3-unit run -> aborted=1, done=0; cooldown entered. Start during cooldown -> rejected, and no new run begins until state=00.
- Async reset mid-RUN: pull reset low between clock edges at cycle 15 -> pump_on, busy and remaining go to 0 without a clock edge. Release, then start with time 5 -> clean 20-cycle run.
- COOLDOWN_UNITS=0: 2-unit run -> busy and pump_on fall together after 8 cycles; a start in the following cycle is accepted.

Source files
------------

// File: rtl/irrigation_pump_controller_pkg.sv
// Shared state encoding, parameter defaults and the duration clamp
// for the irrigation pump controller and its prescaler.
package irrigation_pump_controller_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StRun      = 2'b01,
        StCooldown = 2'b10
    } pump_state_e;

    localparam int unsigned DefTickCycles    = 50_000_000;
    localparam int unsigned DefMaxUnits      = 60;
    localparam int unsigned DefCooldownUnits = 30;
    localparam int unsigned UnitsCeiling     = 255;

    // Limits above the 8-bit range saturate at 255.
    function automatic logic [7:0] clamp_units(input logic [7:0] req, input int unsigned limit);
        int unsigned eff;
        eff = (limit > UnitsCeiling) ? UnitsCeiling : limit;
        return (32'(req) > eff) ? 8'(eff) : req;
    endfunction

endpackage

// File: rtl/irrigation_tick_prescaler.sv
// Free-running 0..TICK_CYCLES-1 counter with a one-cycle tick on the wrap
// cycle; clear restarts the count from zero.
module irrigation_tick_prescaler
    import irrigation_pump_controller_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = DefTickCycles
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TICK_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Tick ignores clear so the caller can observe a wrap while restarting.
    assign tick = enable && (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/irrigation_pump_controller.sv
// Turns one accepted irrigation request into a timed pump-on interval with
// rain/manual abort, start rejection and a post-run cooldown.
module irrigation_pump_controller
    import irrigation_pump_controller_pkg::*;
#(
    parameter int unsigned TICK_CYCLES    = DefTickCycles,
    parameter int unsigned MAX_UNITS      = DefMaxUnits,
    parameter int unsigned COOLDOWN_UNITS = DefCooldownUnits
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] irrigation_time,
    input  logic       rain_present,
    input  logic       manual_stop,
    output logic       pump_on,
    output logic       busy,
    output logic [7:0] remaining,
    output logic       done,
    output logic       aborted,
    output logic       rejected,
    output logic [1:0] state
);

    localparam logic [7:0] CoolLoad = clamp_units(8'hFF, COOLDOWN_UNITS);

    pump_state_e state_q, state_d;
    logic [7:0]  rem_q, rem_d;
    logic        pump_q, pump_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;
    logic        rej_q, rej_d;
    logic        presc_clear;
    logic        tick;

    irrigation_tick_prescaler #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (presc_clear),
        .enable(state_q != StIdle),
        .tick  (tick)
    );

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        rej_d       = 1'b0;
        presc_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (rain_present || manual_stop || irrigation_time == 8'd0) begin
                        rej_d = 1'b1;
                    end else begin
                        state_d     = StRun;
                        rem_d       = clamp_units(irrigation_time, MAX_UNITS);
                        presc_clear = 1'b1;
                    end
                end
            end
            StRun: begin
                // Abort takes priority over a coincident final tick.
                if (rain_present || manual_stop) begin
                    abort_d = 1'b1;
                end else if (tick) begin
                    if (rem_q <= 8'd1) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d = rem_q - 8'd1;
                    end
                end
                if (abort_d || done_d) begin
                    presc_clear = 1'b1;
                    if (CoolLoad == 8'd0) begin
                        state_d = StIdle;
                        rem_d   = 8'd0;
                    end else begin
                        state_d = StCooldown;
                        rem_d   = CoolLoad;
                    end
                end
            end
            StCooldown: begin
                rej_d = start;
                if (tick) begin
                    if (rem_q <= 8'd1) begin
                        state_d = StIdle;
                        rem_d   = 8'd0;
                    end else begin
                        rem_d = rem_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                rem_d   = 8'd0;
            end
        endcase
        pump_d = (state_d == StRun);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            rem_q   <= 8'd0;
            pump_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pump_q  <= pump_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            rej_q   <= rej_d;
        end
    end

    assign pump_on   = pump_q;
    assign busy      = busy_q;
    assign remaining = rem_q;
    assign done      = done_q;
    assign aborted   = abort_q;
    assign rejected  = rej_q;
    assign state     = state_q;

endmodule

// File: tb/tb_irrigation_pump_controller.sv
// Bench for irrigation_pump_controller: two instances (cooldown 2 and 0 units)
// share stimulus and are compared against a timeline-based reference model.
module tb_irrigation_pump_controller;

    localparam int unsigned T    = 4;
    localparam int unsigned MAXU = 60;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       rain  = 1'b0;
    logic       stop  = 1'b0;
    logic [7:0] itime = 8'd0;

    logic       pump_on   [2];
    logic       busy      [2];
    logic [7:0] remaining [2];
    logic       done      [2];
    logic       aborted   [2];
    logic       rejected  [2];
    logic [1:0] state     [2];
    logic [14:0] obs      [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: mode 0 idle, 1 running, 2 cooling; t0 = edge index the phase began.
    int          m_mode [2];
    int          m_t0   [2];
    int          m_n    [2];
    logic [14:0] exp_v  [2];

    always #5 clk = ~clk;

    irrigation_pump_controller #(
        .TICK_CYCLES(T), .MAX_UNITS(MAXU), .COOLDOWN_UNITS(2)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start), .irrigation_time(itime),
        .rain_present(rain), .manual_stop(stop), .pump_on(pump_on[0]), .busy(busy[0]),
        .remaining(remaining[0]), .done(done[0]), .aborted(aborted[0]),
        .rejected(rejected[0]), .state(state[0])
    );

    irrigation_pump_controller #(
        .TICK_CYCLES(T), .MAX_UNITS(MAXU), .COOLDOWN_UNITS(0)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start), .irrigation_time(itime),
        .rain_present(rain), .manual_stop(stop), .pump_on(pump_on[1]), .busy(busy[1]),
        .remaining(remaining[1]), .done(done[1]), .aborted(aborted[1]),
        .rejected(rejected[1]), .state(state[1])
    );

    assign obs[0] = {pump_on[0], busy[0], remaining[0], done[0], aborted[0], rejected[0], state[0]};
    assign obs[1] = {pump_on[1], busy[1], remaining[1], done[1], aborted[1], rejected[1], state[1]};

    function automatic int cool_units(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_t0[i]   = 0;
            m_n[i]    = 0;
            exp_v[i]  = '0;
        end
    endtask

    task automatic model_edge();
        int  cu, rem;
        bit  d, a, r;
        for (int i = 0; i < 2; i++) begin
            cu = cool_units(i);
            d = 0; a = 0; r = 0;
            case (m_mode[i])
                0: begin
                    if (start) begin
                        if (!rain && !stop && itime != 8'd0) begin
                            m_mode[i] = 1;
                            m_t0[i]   = cyc;
                            m_n[i]    = (int'(itime) > MAXU) ? MAXU : int'(itime);
                        end else begin
                            r = 1;
                        end
                    end
                end
                1: begin
                    if (rain || stop) a = 1;
                    else if (cyc == m_t0[i] + m_n[i] * T) d = 1;
                    if (a || d) begin
                        if (cu == 0) m_mode[i] = 0;
                        else begin
                            m_mode[i] = 2;
                            m_t0[i]   = cyc;
                        end
                    end
                end
                default: begin
                    r = start;
                    if (cyc == m_t0[i] + cu * T) m_mode[i] = 0;
                end
            endcase
            if (m_mode[i] == 1)      rem = m_n[i] - (cyc - m_t0[i]) / T;
            else if (m_mode[i] == 2) rem = cu - (cyc - m_t0[i]) / T;
            else                     rem = 0;
            exp_v[i] = {m_mode[i] == 1, m_mode[i] != 0, 8'(rem), d, a, r, 2'(m_mode[i])};
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (reset) model_edge();
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((state[0] != 2'b00 || state[1] != 2'b00) && k < 600) begin
            step();
            k++;
        end
        if (state[0] != 2'b00 || state[1] != 2'b00) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_drain timeout: state got %b/%b want 00/00", tag, state[0], state[1]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs[i] !== exp_v[i] || obs[i] !== 15'd0) begin
                n_bad++;
                $display("FAIL reset inst%0d: got %h want %h", i, obs[i], 15'd0);
            end
        end
        #3 reset = 1'b1;
    endtask

    task automatic test_normal_run();
        int pump_cnt, done_cnt, busy_after;
        pump_cnt = 0; done_cnt = 0; busy_after = 0;
        itime = 8'd10; start = 1'b1;
        step();
        start = 1'b0; itime = 8'($urandom);
        n_cmp++;
        if (pump_on[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL normal_first_cycle pump_on got %b want 1", pump_on[0]);
        end
        for (int k = 0; k < 80; k++) begin
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== exp_v[i]) begin
                    n_bad++;
                    $display("FAIL normal inst%0d cyc%0d: got %h want %h", i, cyc, obs[i], exp_v[i]);
                end
            end
            if (pump_on[0]) pump_cnt++;
            else if (busy[0]) busy_after++;
            done_cnt += int'(done[0]);
            step();
        end
        n_cmp += 4;
        if (pump_cnt !== 40) begin
            n_bad++; $display("FAIL normal_pump_cycles got %0d want 40", pump_cnt);
        end
        if (done_cnt !== 1) begin
            n_bad++; $display("FAIL normal_done_count got %0d want 1", done_cnt);
        end
        if (busy_after !== 8) begin
            n_bad++; $display("FAIL normal_cooldown_cycles got %0d want 8", busy_after);
        end
        if (state[0] !== 2'b00) begin
            n_bad++; $display("FAIL normal_final_state got %b want 00", state[0]);
        end
    endtask

    task automatic test_clamp_reject();
        int pump_cnt;
        pump_cnt = 0;
        itime = 8'd200; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== exp_v[i]) begin
                    n_bad++;
                    $display("FAIL clamp inst%0d cyc%0d: got %h want %h", i, cyc, obs[i], exp_v[i]);
                end
            end
            if (pump_on[0]) pump_cnt++;
            step();
        end
        n_cmp++;
        if (pump_cnt !== 240) begin
            n_bad++; $display("FAIL clamp_pump_cycles got %0d want 240", pump_cnt);
        end
        wait_idle("clamp");
        itime = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++;
        if (rejected[0] !== 1'b1 || pump_on[0] !== 1'b0 || state[0] !== 2'b00) begin
            n_bad++;
            $display("FAIL reject_zero rej/pump/state got %b/%b/%b want 1/0/00",
                     rejected[0], pump_on[0], state[0]);
        end
        step();
        n_cmp++;
        if (rejected[0] !== 1'b0) begin
            n_bad++; $display("FAIL reject_zero_pulse_width got %b want 0", rejected[0]);
        end
        itime = 8'd5; rain = 1'b1; start = 1'b1;
        step();
        start = 1'b0; rain = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs[i] !== exp_v[i] || rejected[i] !== 1'b1 || state[i] !== 2'b00) begin
                n_bad++;
                $display("FAIL reject_rain inst%0d: got %h want %h", i, obs[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_rain_abort();
        int done_cnt;
        done_cnt = 0;
        itime = 8'd45; start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) begin
            done_cnt += int'(done[0]);
            step();
        end
        rain = 1'b1;
        step();
        rain = 1'b0;
        n_cmp++;
        if (aborted[0] !== 1'b1 || pump_on[0] !== 1'b0 || state[0] !== 2'b10
            || remaining[0] !== 8'd2) begin
            n_bad++;
            $display("FAIL rain_abort abort/pump/state/rem got %b/%b/%b/%0d want 1/0/10/2",
                     aborted[0], pump_on[0], state[0], remaining[0]);
        end
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== exp_v[i]) begin
                    n_bad++;
                    $display("FAIL rain inst%0d cyc%0d: got %h want %h", i, cyc, obs[i], exp_v[i]);
                end
            end
            done_cnt += int'(done[0]);
            step();
        end
        n_cmp++;
        if (done_cnt !== 0) begin
            n_bad++; $display("FAIL rain_done_count got %0d want 0", done_cnt);
        end
    endtask

    task automatic test_simultaneous();
        int pump_cnt;
        pump_cnt = 0;
        itime = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (11) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_cmp++;
        if (aborted[0] !== 1'b1 || done[0] !== 1'b0 || state[0] !== 2'b10) begin
            n_bad++;
            $display("FAIL simul_abort abort/done/state got %b/%b/%b want 1/0/10",
                     aborted[0], done[0], state[0]);
        end
        itime = 8'd7; start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++;
        if (rejected[0] !== 1'b1 || state[0] !== 2'b10) begin
            n_bad++;
            $display("FAIL simul_cool_reject rej/state got %b/%b want 1/10", rejected[0], state[0]);
        end
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== exp_v[i]) begin
                    n_bad++;
                    $display("FAIL simul inst%0d cyc%0d: got %h want %h", i, cyc, obs[i], exp_v[i]);
                end
            end
            if (pump_on[0]) pump_cnt++;
            step();
        end
        n_cmp++;
        if (pump_cnt !== 0) begin
            n_bad++; $display("FAIL simul_no_restart pump cycles got %0d want 0", pump_cnt);
        end
    endtask

    task automatic test_async_reset();
        int pump_cnt [2];
        pump_cnt[0] = 0; pump_cnt[1] = 0;
        itime = 8'd30; start = 1'b1;
        step();
        start = 1'b0;
        repeat (14) step();
        #3 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (pump_on[i] !== 1'b0 || busy[i] !== 1'b0 || remaining[i] !== 8'd0) begin
                n_bad++;
                $display("FAIL async_reset inst%0d pump/busy/rem got %b/%b/%0d want 0/0/0",
                         i, pump_on[i], busy[i], remaining[i]);
            end
        end
        model_reset();
        step();
        reset = 1'b1;
        itime = 8'd5; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== exp_v[i]) begin
                    n_bad++;
                    $display("FAIL post_reset inst%0d cyc%0d: got %h want %h", i, cyc, obs[i], exp_v[i]);
                end
                if (pump_on[i]) pump_cnt[i]++;
            end
            step();
        end
        n_cmp++;
        if (pump_cnt[0] !== 20 || pump_cnt[1] !== 20) begin
            n_bad++;
            $display("FAIL post_reset_run pump cycles got %0d/%0d want 20/20", pump_cnt[0], pump_cnt[1]);
        end
    endtask

    task automatic test_no_cooldown();
        int pump_cnt;
        pump_cnt = 0;
        itime = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 20 && pump_on[1]; k++) begin
            pump_cnt++;
            step();
        end
        n_cmp++;
        if (pump_cnt !== 8 || busy[1] !== 1'b0 || state[1] !== 2'b00 || done[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL nocool_end cycles/busy/state/done got %0d/%b/%b/%b want 8/0/00/1",
                     pump_cnt, busy[1], state[1], done[1]);
        end
        itime = 8'd4; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs[i] !== exp_v[i]) begin
                n_bad++;
                $display("FAIL nocool_restart inst%0d: got %h want %h", i, obs[i], exp_v[i]);
            end
        end
        n_cmp++;
        if (state[1] !== 2'b01 || pump_on[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL nocool_accept state/pump got %b/%b want 01/1", state[1], pump_on[1]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0)       itime = 8'd0;
            else if ($urandom_range(0, 19) == 0) itime = 8'($urandom_range(61, 255));
            else                                 itime = 8'($urandom_range(1, 12));
            rain = ($urandom_range(0, 59) == 0);
            stop = ($urandom_range(0, 89) == 0);
            step();
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== exp_v[i]) begin
                    n_bad++;
                    $display("FAIL random inst%0d cyc%0d: got %h want %h", i, cyc, obs[i], exp_v[i]);
                end
                n_cmp++;
                if (int'(done[i]) + int'(aborted[i]) + int'(rejected[i]) > 1) begin
                    n_bad++;
                    $display("FAIL pulse_exclusive inst%0d cyc%0d: got %b%b%b want at most one",
                             i, cyc, done[i], aborted[i], rejected[i]);
                end
            end
        end
        start = 1'b0; rain = 1'b0; stop = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal_run();
        wait_idle("normal");
        test_clamp_reject();
        wait_idle("clamp2");
        test_rain_abort();
        wait_idle("rain");
        test_simultaneous();
        wait_idle("simul");
        test_async_reset();
        wait_idle("async");
        test_no_cooldown();
        wait_idle("nocool");
        test_random();
        wait_idle("random");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
